// File: rtl/irq_pending_capture.sv
// irq_pending_capture
//
// Capture stage in front of the 8-input priority encoder. Each request line
// is synchronized, then tracked either as a rising-edge event (held until the
// consumer clears it by index) or as a level (pending follows the line). Edge
// events that arrive while the line is already pending set a sticky
// per-line overflow flag.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   irq_in     [N] asynchronous request lines
//   edge_sel   [N] 1 = rising-edge mode, 0 = level mode (per line)
//   mask       [N] 1 = forward line to encoder, 0 = hold but hide
//   global_en  master enable for the encoder
//   clr_valid  one-cycle clear strobe from the consumer
//   clr_idx    [3] pending bit to clear when clr_valid=1
//   ovf_clr    clears all overflow flags
//   pend_out   [N] pending & mask, drives encoder `in`
//   pend_en    global_en & |pend_out, drives encoder `en`
//   pend_raw   [N] unmasked pending register
//   overflow   [N] sticky lost-edge flags
module irq_pending_capture #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] irq_in,
  input  logic [N-1:0] edge_sel,
  input  logic [N-1:0] mask,
  input  logic         global_en,
  input  logic         clr_valid,
  input  logic [2:0]   clr_idx,
  input  logic         ovf_clr,
  output logic [N-1:0] pend_out,
  output logic         pend_en,
  output logic [N-1:0] pend_raw,
  output logic [N-1:0] overflow
);

  logic [N-1:0] sync_reg [SYNC_STAGES];
  logic [N-1:0] s;
  logic [N-1:0] prev_reg;
  logic [N-1:0] pend_reg;
  logic [N-1:0] ovf_reg;
  logic [N-1:0] rise;
  logic [N-1:0] clr_hit;
  logic [N-1:0] pend_next;
  logic [N-1:0] ovf_next;

  // Synchronizer chain; stage 0 is the metastability-catching flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= '0;
      end
    end else begin
      sync_reg[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
    end
  end

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~prev_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_line
      assign clr_hit[gi] = clr_valid && (clr_idx == 3'(gi));

      // Edge mode: a new edge beats a same-cycle clear. Level mode: follow s,
      // clears are ignored because the source itself must be deasserted.
      always_comb begin
        pend_next[gi] = pend_reg[gi];
        if (edge_sel[gi]) begin
          if (rise[gi]) begin
            pend_next[gi] = 1'b1;
          end else if (clr_hit[gi]) begin
            pend_next[gi] = 1'b0;
          end
        end else begin
          pend_next[gi] = s[gi];
        end
      end

      // An edge is lost only if the bit is still pending and is not being
      // consumed this very cycle. A new set beats ovf_clr.
      always_comb begin
        ovf_next[gi] = ovf_reg[gi] & ~ovf_clr;
        if (edge_sel[gi] && rise[gi] && pend_reg[gi] && !clr_hit[gi]) begin
          ovf_next[gi] = 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= '0;
      pend_reg <= '0;
      ovf_reg  <= '0;
    end else begin
      // prev tracks in both modes so a mode switch never fakes an edge.
      prev_reg <= s;
      pend_reg <= pend_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign pend_raw = pend_reg;
  assign overflow = ovf_reg;
  assign pend_out = pend_reg & mask;
  assign pend_en  = global_en & (|pend_out);

endmodule

// File: tb/tb_irq_pending_capture.sv
module tb_irq_pending_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] edge_sel;
  logic [7:0] mask;
  logic       global_en;
  logic       clr_valid;
  logic [2:0] clr_idx;
  logic       ovf_clr;
  logic [7:0] pend_out;
  logic       pend_en;
  logic [7:0] pend_raw;
  logic [7:0] overflow;

  int checks   = 0;
  int failures = 0;

  irq_pending_capture #(.N(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .edge_sel  (edge_sel),
    .mask      (mask),
    .global_en (global_en),
    .clr_valid (clr_valid),
    .clr_idx   (clr_idx),
    .ovf_clr   (ovf_clr),
    .pend_out  (pend_out),
    .pend_en   (pend_en),
    .pend_raw  (pend_raw),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n = 1);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
    $display("check %-22s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    irq_in    = 8'h00;
    edge_sel  = 8'hFF;
    mask      = 8'hFF;
    global_en = 1'b1;
    clr_valid = 1'b0;
    clr_idx   = 3'd0;
    ovf_clr   = 1'b0;

    // Reset state
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("reset_pend_out", pend_out, 8'h00);
    chk("reset_pend_en", {7'd0, pend_en}, 8'h00);
    chk("reset_pend_raw", pend_raw, 8'h00);
    chk("reset_overflow", overflow, 8'h00);

    // Edge mode line 5: visible exactly 3 edges after assertion
    irq_in = 8'h20;
    tick(2);
    chk("l5_edge2_raw", pend_raw, 8'h00);
    tick(1);
    chk("l5_edge3_raw", pend_raw, 8'h20);
    chk("l5_pend_out", pend_out, 8'h20);
    chk("l5_pend_en", {7'd0, pend_en}, 8'h01);
    irq_in    = 8'h00;
    clr_valid = 1'b1;
    clr_idx   = 3'd5;
    tick(1);
    clr_valid = 1'b0;
    chk("l5_clr_raw", pend_raw, 8'h00);
    chk("l5_clr_en", {7'd0, pend_en}, 8'h00);

    // Edge mode line 2: second edge while pending -> overflow
    irq_in = 8'h04;
    tick(3);
    chk("l2_first_raw", pend_raw, 8'h04);
    irq_in = 8'h00;
    tick(3);
    irq_in = 8'h04;
    tick(2);
    chk("l2_ovf_early", overflow, 8'h00);
    tick(1);
    chk("l2_ovf_set", overflow, 8'h04);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("l2_ovf_clr", overflow, 8'h00);

    // Same-cycle edge and clear: set wins, no overflow
    irq_in = 8'h00;
    tick(3);
    irq_in = 8'h04;
    tick(2);
    clr_valid = 1'b1;
    clr_idx   = 3'd2;
    tick(1);
    clr_valid = 1'b0;
    chk("l2_setwins_raw", pend_raw, 8'h04);
    chk("l2_setwins_ovf", overflow, 8'h00);
    clr_valid = 1'b1;
    tick(1);
    clr_valid = 1'b0;
    chk("l2_final_clr", pend_raw, 8'h00);
    irq_in = 8'h00;
    tick(3);

    // Level mode line 7: clear ignored, drops 3 edges after deassert
    edge_sel = 8'h7F;
    irq_in   = 8'h80;
    tick(3);
    chk("l7_level_raw", pend_raw, 8'h80);
    clr_valid = 1'b1;
    clr_idx   = 3'd7;
    tick(1);
    clr_valid = 1'b0;
    chk("l7_clr_noop", pend_raw, 8'h80);
    irq_in = 8'h00;
    tick(2);
    chk("l7_deassert2", pend_raw, 8'h80);
    tick(1);
    chk("l7_deassert3", pend_raw, 8'h00);
    edge_sel = 8'hFF;

    // Masking: held while hidden, exposed without a new edge
    mask   = 8'h00;
    irq_in = 8'h01;
    tick(3);
    chk("mask_raw", pend_raw, 8'h01);
    chk("mask_pend_out", pend_out, 8'h00);
    chk("mask_pend_en", {7'd0, pend_en}, 8'h00);
    mask = 8'h01;
    #1;
    chk("unmask_pend_out", pend_out, 8'h01);
    chk("unmask_pend_en", {7'd0, pend_en}, 8'h01);
    global_en = 1'b0;
    #1;
    chk("gen_off_pend_en", {7'd0, pend_en}, 8'h00);
    global_en = 1'b1;
    mask      = 8'hFF;
    tick(1);

    // Build pending 0x81 with overflow on line 0, then async reset
    irq_in = 8'h80;
    tick(3);
    irq_in = 8'h81;
    tick(3);
    chk("pre_rst_raw", pend_raw, 8'h81);
    chk("pre_rst_ovf", overflow, 8'h01);
    chk("pre_rst_out", pend_out, 8'h81);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_raw", pend_raw, 8'h00);
    chk("async_rst_out", pend_out, 8'h00);
    chk("async_rst_en", {7'd0, pend_en}, 8'h00);
    chk("async_rst_ovf", overflow, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
